eth_fcs_append: RTL and testbench

//  Ethernet TX framing stage upstream of the MAC/PHY byte interface. Accepts a frame byte stream
//  (valid/ready/last), pads short frames with 0x00 to MIN_LEN, appends the 4-byte CRC-32 FCS
//  and enforces an inter-frame gap. Registered output; the CRC-32 byte engine is internal.

---
 rtl/eth_pkg.sv | 19 +
 rtl/crc32_d8_next.sv | 28 ++
 rtl/eth_fcs_append.sv | 143 ++++++++++++++
 tb/tb_eth_fcs_append.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet TX/RX framing blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package eth_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PAD,
    FCS,
    GAP
  } fcs_state_t;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam int          ETH_MIN_LEN     = 60;
  localparam int          ETH_IFG         = 12;

endpackage

// File: rtl/crc32_d8_next.sv
// Reflected CRC-32 update for one byte, data bit 0 shifted in first.
// Latency: combinational.
// Backpressure: none; the caller decides when to register crc_out.
//
// Ports:
//   crc_in  [31:0]  running CRC register
//   d       [7:0]   byte to fold in
//   crc_out [31:0]  CRC after the byte
module crc32_d8_next
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  d,
  output logic [31:0] crc_out
);

  always_comb begin
    crc_out = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (crc_out[0] ^ d[i]) begin
        crc_out = (crc_out >> 1) ^ CRC32_POLY_REFL;
      end else begin
        crc_out = crc_out >> 1;
      end
    end
  end

endmodule

// File: rtl/eth_fcs_append.sv
// Ethernet TX framing: pads short frames with zeros, appends CRC-32 FCS, enforces IFG.
// Latency: 1 cycle from input accept to the byte appearing on m_data (registered output).
// Backpressure: m_ready stall holds the output register; s_ready is low while stalled,
//   while padding/emitting FCS, and for IFG cycles after the frame's last FCS byte.
//
// Ports:
//   clk, reset                synchronous active-high reset
//   s_data/s_valid/s_last     frame byte stream in, s_ready accepts
//   m_data/m_valid/m_last     framed byte stream out (m_last on final FCS byte), m_ready accepts
//   busy                      high whenever a frame or gap is in progress
module eth_fcs_append
  import eth_pkg::*;
#(
  parameter int MIN_LEN = ETH_MIN_LEN,
  parameter int IFG     = ETH_IFG
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] m_data,
  output logic       m_valid,
  output logic       m_last,
  input  logic       m_ready,
  output logic       busy
);

  fcs_state_t  state;
  logic [31:0] crc;
  logic [31:0] crc_nxt;
  logic [15:0] len;
  logic [16:0] len_p1;
  logic [15:0] len_sat;
  logic [1:0]  fcs_idx;
  logic [15:0] ifg_cnt;
  logic [7:0]  crc_byte;
  logic [7:0]  fcs_byte;
  logic        adv;
  logic        accept;

  // Output register may take a new byte when empty or being drained this cycle.
  assign adv     = ~m_valid | m_ready;
  assign s_ready = ~reset & adv & ((state == IDLE) || (state == DATA));
  assign accept  = s_valid & s_ready;
  assign busy    = (state != IDLE);

  // Pad bytes are zero and are covered by the CRC just like payload.
  assign crc_byte = (state == PAD) ? 8'h00 : s_data;

  crc32_d8_next u_crc (
    .crc_in  (crc),
    .d       (crc_byte),
    .crc_out (crc_nxt)
  );

  // len+1 computed one bit wider so the pad comparison never wraps.
  assign len_p1   = {1'b0, len} + 17'd1;
  assign len_sat  = (&len) ? len : len_p1[15:0];
  assign fcs_byte = ~crc[{fcs_idx, 3'b000} +: 8];

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      crc     <= CRC32_INIT;
      len     <= 16'd0;
      fcs_idx <= 2'd0;
      ifg_cnt <= 16'd0;
      m_data  <= 8'h00;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end else begin
      // Drained with nothing new loaded: output goes empty.
      if (adv) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end

      case (state)
        IDLE, DATA: begin
          if (accept) begin
            m_data  <= s_data;
            m_valid <= 1'b1;
            crc     <= crc_nxt;
            len     <= len_sat;
            if (s_last) begin
              fcs_idx <= 2'd0;
              state   <= (len_p1 < 17'(MIN_LEN)) ? PAD : FCS;
            end else begin
              state <= DATA;
            end
          end
        end

        PAD: begin
          if (adv) begin
            m_data  <= 8'h00;
            m_valid <= 1'b1;
            crc     <= crc_nxt;
            len     <= len_sat;
            if (len_p1 >= 17'(MIN_LEN)) begin
              state <= FCS;
            end
          end
        end

        FCS: begin
          if (m_last) begin
            // Final FCS byte is in the output register; leave only once it is taken.
            if (m_ready) begin
              crc <= CRC32_INIT;
              len <= 16'd0;
              if (IFG == 0) begin
                state <= IDLE;
              end else begin
                ifg_cnt <= 16'd0;
                state   <= GAP;
              end
            end
          end else if (adv) begin
            m_data  <= fcs_byte;
            m_valid <= 1'b1;
            m_last  <= (fcs_idx == 2'd3);
            fcs_idx <= fcs_idx + 2'd1;
          end
        end

        GAP: begin
          if (ifg_cnt == 16'(IFG - 1)) begin
            ifg_cnt <= 16'd0;
            state   <= IDLE;
          end else begin
            ifg_cnt <= ifg_cnt + 16'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_fcs_append.sv
// Bench for eth_fcs_append: two instances (no pad/no gap, and 60-byte pad/12-cycle gap),
// random payloads and random m_ready, checked against a software framing model.
module tb_eth_fcs_append;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset   [2];
  logic [7:0] s_data  [2];
  logic       s_valid [2];
  logic       s_last  [2];
  logic       s_ready [2];
  logic [7:0] m_data  [2];
  logic       m_valid [2];
  logic       m_last  [2];
  logic       m_ready [2];
  logic       busy    [2];

  eth_fcs_append #(.MIN_LEN(0), .IFG(0)) dut0 (
    .clk(clk), .reset(reset[0]), .s_data(s_data[0]), .s_valid(s_valid[0]),
    .s_last(s_last[0]), .s_ready(s_ready[0]), .m_data(m_data[0]), .m_valid(m_valid[0]),
    .m_last(m_last[0]), .m_ready(m_ready[0]), .busy(busy[0])
  );

  eth_fcs_append #(.MIN_LEN(60), .IFG(12)) dut1 (
    .clk(clk), .reset(reset[1]), .s_data(s_data[1]), .s_valid(s_valid[1]),
    .s_last(s_last[1]), .s_ready(s_ready[1]), .m_data(m_data[1]), .m_valid(m_valid[1]),
    .m_last(m_last[1]), .m_ready(m_ready[1]), .busy(busy[1])
  );

  int n_asrt = 0;
  int n_fail = 0;
  int stab_bad = 0;
  bit rnd [2] = '{1'b0, 1'b0};

  logic [7:0] cap0_d[$], cap1_d[$], got_d[$], exp_d[$];
  logic       cap0_l[$], cap1_l[$], got_l[$], exp_l[$];

  // Inter-frame gap measurement on dut1
  bit gap_arm = 1'b0;
  bit gap_on  = 1'b0;
  int gap_cnt = 0;
  int gap_res = -1;
  int gap_bad = 0;

  // Downstream ready: always-on or coin flip, changed just after each rising edge.
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 2; k++) begin
      m_ready[k] = rnd[k] ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output capture and stall-stability watch, sampled on the falling edge.
  logic [7:0] hold_d [2];
  logic       hold_l [2];
  bit         held   [2] = '{1'b0, 1'b0};
  always @(negedge clk) begin
    if (!reset[0] && m_valid[0] && m_ready[0]) begin
      cap0_d.push_back(m_data[0]);
      cap0_l.push_back(m_last[0]);
    end
    if (!reset[1] && m_valid[1] && m_ready[1]) begin
      cap1_d.push_back(m_data[1]);
      cap1_l.push_back(m_last[1]);
    end
    for (int k = 0; k < 2; k++) begin
      if (held[k] && !reset[k] &&
          !(m_valid[k] && m_data[k] === hold_d[k] && m_last[k] === hold_l[k])) begin
        stab_bad++;
      end
      held[k]   = !reset[k] && m_valid[k] && !m_ready[k];
      hold_d[k] = m_data[k];
      hold_l[k] = m_last[k];
    end
    if (gap_arm) begin
      if (gap_on) begin
        if (s_valid[1] && s_ready[1]) begin
          gap_res = gap_cnt;
          gap_on  = 1'b0;
          gap_arm = 1'b0;
        end else begin
          gap_cnt++;
          if (s_ready[1] || m_valid[1]) gap_bad++;
        end
      end else if (m_valid[1] && m_ready[1] && m_last[1]) begin
        gap_on  = 1'b1;
        gap_cnt = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_asrt++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Software CRC-32 (IEEE, reflected), returns the FCS value ~crc.
  function automatic logic [31:0] crc32_sw(input logic [7:0] b[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (b[i]) begin
      c = c ^ {24'd0, b[i]};
      for (int j = 0; j < 8; j++) begin
        c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
    end
    return ~c;
  endfunction

  // Expected wire image of one frame appended to exp_d/exp_l.
  task automatic add_exp(input logic [7:0] pl[$], input int min_len);
    logic [7:0]  fr[$];
    logic [31:0] f;
    fr = pl;
    while (fr.size() < min_len) fr.push_back(8'h00);
    f = crc32_sw(fr);
    fr.push_back(f[7:0]);
    fr.push_back(f[15:8]);
    fr.push_back(f[23:16]);
    fr.push_back(f[31:24]);
    foreach (fr[i]) begin
      exp_d.push_back(fr[i]);
      exp_l.push_back(i == fr.size() - 1);
    end
  endtask

  task automatic send(input int k, input logic [7:0] pl[$], input int bubble, input bit with_last);
    for (int i = 0; i < pl.size(); i++) begin
      int t;
      bit acc;
      if (bubble > 0 && i > 0 && (i % bubble) == 0) begin
        s_valid[k] = 1'b0;
        @(posedge clk);
        #1;
      end
      s_valid[k] = 1'b1;
      s_data[k]  = pl[i];
      s_last[k]  = with_last && (i == pl.size() - 1);
      t   = 0;
      acc = 1'b0;
      while (!acc && t < 1000) begin
        @(negedge clk);
        acc = s_ready[k];
        @(posedge clk);
        #1;
        t++;
      end
      check($sformatf("dut%0d accept byte %0d", k, i), {31'd0, acc}, 32'd1);
    end
    s_valid[k] = 1'b0;
    s_last[k]  = 1'b0;
  endtask

  // Wait (bounded) for n output bytes, settle, then move the capture into got_d/got_l.
  task automatic get_out(input int k, input int n);
    int t;
    t = 0;
    while (((k == 0) ? cap0_d.size() : cap1_d.size()) < n && t < 5000) begin
      @(posedge clk);
      t++;
    end
    check($sformatf("dut%0d output wait expired", k), {31'd0, t >= 5000}, 32'd0);
    repeat (20) @(posedge clk);
    #1;
    if (k == 0) begin
      got_d = cap0_d; got_l = cap0_l; cap0_d = {}; cap0_l = {};
    end else begin
      got_d = cap1_d; got_l = cap1_l; cap1_d = {}; cap1_l = {};
    end
  endtask

  task automatic cmp(input string tag);
    int mism;
    mism = 0;
    check({tag, " length"}, got_d.size(), exp_d.size());
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) mism++;
    end
    check({tag, " byte/last mismatches"}, mism, 0);
    exp_d = {};
    exp_l = {};
  endtask

  initial begin
    logic [7:0] pl[$];
    logic [7:0] pb[$];
    int n_last;

    for (int k = 0; k < 2; k++) begin
      reset[k] = 1'b1; s_valid[k] = 1'b0; s_last[k] = 1'b0; s_data[k] = 8'h00;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst%0d m_valid", k), {31'd0, m_valid[k]}, 32'd0);
      check($sformatf("rst%0d m_last", k),  {31'd0, m_last[k]},  32'd0);
      check($sformatf("rst%0d m_data", k),  {24'd0, m_data[k]},  32'd0);
      check($sformatf("rst%0d s_ready", k), {31'd0, s_ready[k]}, 32'd0);
      check($sformatf("rst%0d busy", k),    {31'd0, busy[k]},    32'd0);
    end
    @(posedge clk);
    #1;
    reset[0] = 1'b0;
    reset[1] = 1'b0;
    cap0_d = {}; cap0_l = {}; cap1_d = {}; cap1_l = {};

    // "123456789", no padding, no gap: CRC-32 check value CBF43926
    pl = {};
    for (int i = 0; i < 9; i++) pl.push_back(8'(8'h31 + i));
    send(0, pl, 0, 1'b1);
    add_exp(pl, 0);
    get_out(0, 13);
    if (got_d.size() == 13) begin
      check("check-string fcs0", {24'd0, got_d[9]},  32'h26);
      check("check-string fcs1", {24'd0, got_d[10]}, 32'h39);
      check("check-string fcs2", {24'd0, got_d[11]}, 32'hF4);
      check("check-string fcs3", {24'd0, got_d[12]}, 32'hCB);
    end
    cmp("check-string");

    // Single zero byte padded to 60, total 64 bytes on the wire
    pl = '{8'h00};
    send(1, pl, 0, 1'b1);
    add_exp(pl, 60);
    get_out(1, 64);
    cmp("min-pad frame");

    // Same string under random downstream backpressure
    rnd[0] = 1'b1;
    pl = {};
    for (int i = 0; i < 9; i++) pl.push_back(8'(8'h31 + i));
    send(0, pl, 0, 1'b1);
    add_exp(pl, 0);
    get_out(0, 13);
    cmp("backpressure string");
    rnd[0] = 1'b0;

    // Back-to-back frames with s_valid held: gap of exactly 12 cycles
    pl = {};
    pb = {};
    for (int i = 0; i < 5; i++) pl.push_back(8'($urandom));
    for (int i = 0; i < 3; i++) pb.push_back(8'($urandom));
    gap_res = -1;
    gap_bad = 0;
    gap_arm = 1'b1;
    send(1, pl, 0, 1'b1);
    send(1, pb, 0, 1'b1);
    add_exp(pl, 60);
    add_exp(pb, 60);
    get_out(1, 128);
    cmp("back-to-back frames");
    check("ifg idle cycles", gap_res, 12);
    check("ifg m_valid/s_ready low", gap_bad, 0);

    // Reset for one cycle after byte 5 of 9: frame dropped, no FCS
    pl = {};
    for (int i = 0; i < 5; i++) pl.push_back(8'(8'h31 + i));
    send(0, pl, 0, 1'b0);
    reset[0] = 1'b1;
    @(posedge clk);
    #1;
    reset[0] = 1'b0;
    @(negedge clk);
    check("mid-frame reset m_valid", {31'd0, m_valid[0]}, 32'd0);
    check("mid-frame reset busy", {31'd0, busy[0]}, 32'd0);
    get_out(0, 0);
    check("mid-frame reset bytes out", got_d.size(), 4);
    n_last = 0;
    foreach (got_l[i]) if (got_l[i]) n_last++;
    check("mid-frame reset no m_last", n_last, 0);
    pl = {};
    for (int i = 0; i < 9; i++) pl.push_back(8'(8'h31 + i));
    send(0, pl, 0, 1'b1);
    add_exp(pl, 0);
    get_out(0, 13);
    if (got_d.size() == 13) begin
      check("post-reset fcs", {got_d[12], got_d[11], got_d[10], got_d[9]}, 32'hCBF43926);
    end
    cmp("post-reset string");

    // 64-byte random payload with input bubbles and random m_ready: no pad
    rnd[1] = 1'b1;
    pl = {};
    for (int i = 0; i < 64; i++) pl.push_back(8'($urandom));
    send(1, pl, 3, 1'b1);
    add_exp(pl, 60);
    get_out(1, 68);
    cmp("64-byte bubbled frame");

    // Random-length frames around the pad threshold
    for (int f = 0; f < 5; f++) begin
      int n;
      n = $urandom_range(1, 80);
      pl = {};
      for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
      send(1, pl, (f % 2) * 4, 1'b1);
      add_exp(pl, 60);
      get_out(1, exp_d.size());
      cmp($sformatf("random frame %0d len %0d", f, n));
    end
    rnd[1] = 1'b0;

    check("m_data stable under stall", stab_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
